fetch_sequencer: RTL and testbench

//  Program-counter and fetch controller for the two-accumulator CPU.

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_timeout_counter.sv | 46 ++++
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: NOP encoding, FSM state encoding,
// and a counter-width helper.
`timescale 1ns/1ps
package fetch_sequencer_pkg;

  // Instruction word presented to the decoder whenever no instruction is live.
  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StFlush = 2'd3
  } state_e;

  // Bits needed to hold 0 .. limit-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Up-counter with terminal-count pulse, used both as the fetch-ack timeout and
// as the post-redirect flush counter.
//   clk_i    in  clock
//   rst_i    in  synchronous active-high reset
//   en_i     in  count this cycle
//   clear_i  in  return to zero (wins over counting and suppresses tc_o)
//   tc_o     out high in the enabled cycle where the count reaches Limit-1;
//                the counter returns to zero on that edge
`timescale 1ns/1ps
module fetch_timeout_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  output logic tc_o
);

  localparam int unsigned W = cnt_width(Limit);
  localparam logic [W-1:0] Last = W'(Limit - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && !clear_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch controller for the two-accumulator CPU. Fetches one
// instruction at a time over a req/ack handshake, holds it for the decoder
// while the datapath stalls, and redirects the PC on taken branches/jumps
// with a flush bubble afterwards.
//   Clock/Reset    clock and synchronous active-high reset
//   oInstrAddr     instruction memory address (always the PC)
//   oInstrReq      fetch request, held until iInstrAck
//   iInstrAck      memory ack, iInstrData valid in the same cycle
//   iInstrData     fetched instruction word
//   oInstruction   instruction to decoder, NOP when oInstrValid is low
//   oInstrValid    oInstruction is live
//   iStall         datapath busy, hold current instruction
//   iBranchTaken   decoder: conditional branch taken
//   iJumpTaken     decoder: unconditional jump
//   iBranchDir     decoder: absolute redirect target
//   oPC            current PC
//   oFetchError    one-cycle pulse on fetch timeout
//   oInstrCount    retired-instruction count, wraps
`timescale 1ns/1ps
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = 10,
  parameter int unsigned           INSTR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned           FLUSH_CYCLES  = 1,
  parameter int unsigned           FETCH_TIMEOUT = 15
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oInstrAddr,
  output logic                   oInstrReq,
  input  logic                   iInstrAck,
  input  logic [INSTR_WIDTH-1:0] iInstrData,
  output logic [INSTR_WIDTH-1:0] oInstruction,
  output logic                   oInstrValid,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic                   iJumpTaken,
  input  logic [ADDR_WIDTH-1:0]  iBranchDir,
  output logic [ADDR_WIDTH-1:0]  oPC,
  output logic                   oFetchError,
  output logic [15:0]            oInstrCount
);

  localparam logic [INSTR_WIDTH-1:0] NopWord = INSTR_WIDTH'(NOP);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic [15:0]              count_q, count_d;

  logic fetch_ack;
  logic timeout_tc;
  logic flush_tc;
  logic redirect;
  logic retire;

  // The request drops for the single cycle that carries the error pulse.
  assign oInstrReq  = (state_q == StFetch) && !err_q;
  assign fetch_ack  = oInstrReq && iInstrAck;
  assign retire     = (state_q == StExec) && !iStall;
  assign redirect   = iJumpTaken || iBranchTaken;

  // Ack clears the count and masks the terminal pulse, so a coinciding ack wins.
  fetch_timeout_counter #(
    .Limit (FETCH_TIMEOUT)
  ) u_timeout (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .en_i    (oInstrReq),
    .clear_i (fetch_ack),
    .tc_o    (timeout_tc)
  );

  fetch_timeout_counter #(
    .Limit (FLUSH_CYCLES)
  ) u_flush (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .en_i    (state_q == StFlush),
    .clear_i (1'b0),
    .tc_o    (flush_tc)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StStart;
      pc_q    <= RESET_PC;
      instr_q <= NopWord;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart: state_d = StFetch;
      StFetch: if (fetch_ack) state_d = StExec;
      StExec:  if (!iStall) state_d = redirect ? StFlush : StFetch;
      StFlush: if (flush_tc) state_d = StFetch;
      default: state_d = StStart;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    err_d   = timeout_tc;
    if (fetch_ack) begin
      instr_d = iInstrData;
      valid_d = 1'b1;
    end
    if (retire) begin
      count_d = count_q + 16'd1;
      pc_d    = redirect ? iBranchDir : pc_q + 1'b1;
      instr_d = NopWord;
      valid_d = 1'b0;
    end
  end

  assign oInstrAddr   = pc_q;
  assign oPC          = pc_q;
  assign oInstruction = instr_q;
  assign oInstrValid  = valid_q;
  assign oFetchError  = err_q;
  assign oInstrCount  = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected fetch
// addresses, retired instructions and per-cycle state snapshots; the monitor
// pops and compares them on the falling edge.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [15:0] NOP_W = 16'h0000;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [9:0]  oInstrAddr;
  logic        oInstrReq;
  logic        iInstrAck;
  logic [15:0] iInstrData;
  logic [15:0] oInstruction;
  logic        oInstrValid;
  logic        iStall;
  logic        iBranchTaken;
  logic        iJumpTaken;
  logic [9:0]  iBranchDir;
  logic [9:0]  oPC;
  logic        oFetchError;
  logic [15:0] oInstrCount;

  logic ack_en;
  logic done;

  typedef struct packed {
    logic [9:0]  pc;
    logic        req;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] count;
    logic        err;
  } probe_t;

  probe_t      probe_q[$];
  logic [9:0]  fetch_q[$];
  logic [15:0] retire_q[$];

  int n_cmp;
  int n_bad;
  int err_seen;

  always #5 Clock = ~Clock;

  // Zero-wait memory: word at address a is 16'hA000 | a.
  assign iInstrAck  = oInstrReq & ack_en;
  assign iInstrData = 16'hA000 | {6'b0, oInstrAddr};

  fetch_sequencer dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .oInstrAddr   (oInstrAddr),
    .oInstrReq    (oInstrReq),
    .iInstrAck    (iInstrAck),
    .iInstrData   (iInstrData),
    .oInstruction (oInstruction),
    .oInstrValid  (oInstrValid),
    .iStall       (iStall),
    .iBranchTaken (iBranchTaken),
    .iJumpTaken   (iJumpTaken),
    .iBranchDir   (iBranchDir),
    .oPC          (oPC),
    .oFetchError  (oFetchError),
    .oInstrCount  (oInstrCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: sole owner of the comparison counters.
  initial begin
    probe_t p;
    n_cmp    = 0;
    n_bad    = 0;
    err_seen = 0;
    forever begin
      @(negedge Clock);
      while (probe_q.size() > 0) begin
        p = probe_q.pop_front();
        check("pc",          32'(oPC),          32'(p.pc));
        check("instr_addr",  32'(oInstrAddr),   32'(p.pc));
        check("instr_req",   32'(oInstrReq),    32'(p.req));
        check("instr_valid", 32'(oInstrValid),  32'(p.valid));
        check("instruction", 32'(oInstruction), 32'(p.instr));
        check("instr_count", 32'(oInstrCount),  32'(p.count));
        check("fetch_error", 32'(oFetchError),  32'(p.err));
      end
      if (oFetchError === 1'b1) err_seen++;
      if (oInstrReq === 1'b1 && iInstrAck === 1'b1) begin
        if (fetch_q.size() == 0) check("unexpected_fetch", 32'(oInstrAddr), 32'hFFFF_FFFF);
        else check("fetch_addr", 32'(oInstrAddr), 32'(fetch_q.pop_front()));
      end
      if (oInstrValid === 1'b1 && iStall === 1'b0) begin
        if (retire_q.size() == 0) check("unexpected_retire", 32'(oInstruction), 32'hFFFF_FFFF);
        else check("retire_instr", 32'(oInstruction), 32'(retire_q.pop_front()));
      end
      if (done) begin
        check("fetch_q_left",  32'(fetch_q.size()),  32'd0);
        check("retire_q_left", 32'(retire_q.size()), 32'd0);
        check("error_pulses",  32'(err_seen),        32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic next();
    @(posedge Clock);
    #1;
  endtask

  task automatic probe(input logic [9:0] pc, input logic req, input logic valid,
                       input logic [15:0] instr, input logic [15:0] count, input logic err);
    probe_t p;
    p.pc = pc; p.req = req; p.valid = valid;
    p.instr = instr; p.count = count; p.err = err;
    probe_q.push_back(p);
  endtask

  // Cycle labels cN count clock cycles from the first edge that sees Reset low.
  initial begin
    Reset = 1'b1; ack_en = 1'b1; done = 1'b0;
    iStall = 1'b0; iBranchTaken = 1'b0; iJumpTaken = 1'b0; iBranchDir = '0;
    repeat (3) next();
    probe(10'h000, 1'b0, 1'b0, NOP_W, 16'd0, 1'b0);
    Reset = 1'b0;

    // Sequential words 0..3, then JMP 0x155 from the word at PC=3.
    for (int a = 0; a < 4; a++) begin
      fetch_q.push_back(10'(a));
      retire_q.push_back(16'hA000 | 16'(a));
    end
    fetch_q.push_back(10'h155);  retire_q.push_back(16'hA155);
    fetch_q.push_back(10'h3FF);  retire_q.push_back(16'hA3FF);
    for (int k = 0; k < 8; k++) begin
      next();
      if (k == 7) begin iJumpTaken = 1'b1; iBranchDir = 10'h155; end
      probe(10'(k >> 1), ~k[0], k[0], k[0] ? (16'hA000 | 16'(k >> 1)) : NOP_W,
            16'(k >> 1), 1'b0);
    end
    next();  // c8 flush bubble
    iJumpTaken = 1'b0;
    probe(10'h155, 1'b0, 1'b0, NOP_W, 16'd4, 1'b0);
    next();  // c9 fetch at target
    probe(10'h155, 1'b1, 1'b0, NOP_W, 16'd4, 1'b0);
    next();  // c10 exec 0x155, jump to 0x3FF
    iJumpTaken = 1'b1; iBranchDir = 10'h3FF;
    probe(10'h155, 1'b0, 1'b1, 16'hA155, 16'd4, 1'b0);
    next();  // c11 flush
    iJumpTaken = 1'b0;
    probe(10'h3FF, 1'b0, 1'b0, NOP_W, 16'd5, 1'b0);
    next();  // c12 fetch 0x3FF
    probe(10'h3FF, 1'b1, 1'b0, NOP_W, 16'd5, 1'b0);
    next();  // c13 exec 0x3FF, branch not taken, stray target ignored
    iBranchDir = 10'h2AA; ack_en = 1'b0;
    probe(10'h3FF, 1'b0, 1'b1, 16'hA3FF, 16'd5, 1'b0);
    next();  // c14 wrapped to 0, no flush; ack withheld from here
    probe(10'h000, 1'b1, 1'b0, NOP_W, 16'd6, 1'b0);
    repeat (14) next();  // c28 last request cycle before timeout
    probe(10'h000, 1'b1, 1'b0, NOP_W, 16'd6, 1'b0);
    next();  // c29 error pulse, request dropped
    probe(10'h000, 1'b0, 1'b0, NOP_W, 16'd6, 1'b1);
    next();  // c30 re-request same PC
    probe(10'h000, 1'b1, 1'b0, NOP_W, 16'd6, 1'b0);
    fetch_q.push_back(10'h000);  retire_q.push_back(16'hA000);
    repeat (14) next();  // c44 ack on the would-be timeout cycle
    ack_en = 1'b1;
    probe(10'h000, 1'b1, 1'b0, NOP_W, 16'd6, 1'b0);

    // Stall three cycles with branch asserted; redirect only on release.
    fetch_q.push_back(10'h0AB);  retire_q.push_back(16'hA0AB);
    for (int s = 0; s < 3; s++) begin
      next();  // c45..c47
      iStall = 1'b1; iBranchTaken = 1'b1; iBranchDir = 10'h0AB;
      probe(10'h000, 1'b0, 1'b1, 16'hA000, 16'd6, 1'b0);
    end
    next();  // c48 stall released
    iStall = 1'b0;
    probe(10'h000, 1'b0, 1'b1, 16'hA000, 16'd6, 1'b0);
    next();  // c49 flush after branch
    iBranchTaken = 1'b0;
    probe(10'h0AB, 1'b0, 1'b0, NOP_W, 16'd7, 1'b0);
    next();  // c50
    probe(10'h0AB, 1'b1, 1'b0, NOP_W, 16'd7, 1'b0);
    next();  // c51
    probe(10'h0AB, 1'b0, 1'b1, 16'hA0AB, 16'd7, 1'b0);
    next();  // c52 request outstanding, reset asserted
    ack_en = 1'b0;
    probe(10'h0AC, 1'b1, 1'b0, NOP_W, 16'd8, 1'b0);
    Reset = 1'b1;
    next();  // c53
    Reset = 1'b0;
    probe(10'h000, 1'b0, 1'b0, NOP_W, 16'd0, 1'b0);
    next();  // c54
    probe(10'h000, 1'b1, 1'b0, NOP_W, 16'd0, 1'b0);
    done = 1'b1;
  end

endmodule
